// File: rtl/mips_pkg.sv
// Constants and types shared by the MIPS datapath: opcodes, fetch defaults
// and the IF/ID register layout.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } ifid_t;

    // Instruction addresses are always word aligned; low bits of targets are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter register: reset value, redirect mux and load enable.
module program_counter
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_redirect,
    input  logic [31:0] i_target,
    input  logic        i_load_en,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4
);

    logic [31:0] r_pc;
    logic [31:0] w_pc_plus4;

    assign w_pc_plus4 = r_pc + 32'd4;

    // Redirect wins over a stalled (load-disabled) PC.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pc <= RESET_PC;
        end else if (i_redirect) begin
            r_pc <= word_align(i_target);
        end else if (i_load_en) begin
            r_pc <= w_pc_plus4;
        end
    end

    assign o_pc       = r_pc;
    assign o_pc_plus4 = w_pc_plus4;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives instruction memory and holds
// the IF/ID pipeline register with stall, flush and an accepted-fetch counter.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned IMEM_AW  = 7
) (
    input  logic               Clk,
    input  logic               Rst,
    output logic [IMEM_AW-1:0] ImemAddr,
    input  logic [31:0]        ImemData,
    input  logic               Stall,
    input  logic               BranchTaken,
    input  logic [31:0]        BranchTarget,
    input  logic               Jump,
    input  logic [31:0]        JumpTarget,
    output logic [31:0]        PC,
    output logic [31:0]        Instruction,
    output logic [31:0]        PCPlus4,
    output logic               Valid,
    output logic [31:0]        FetchCount
);

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;
    ifid_t       r_ifid;
    logic [31:0] r_fetch_count;

    assign w_redirect = BranchTaken | Jump;
    assign w_target   = BranchTaken ? BranchTarget : JumpTarget;

    program_counter #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .i_clk      (Clk),
        .i_rst_n    (Rst),
        .i_redirect (w_redirect),
        .i_target   (w_target),
        .i_load_en  (!Stall),
        .o_pc       (PC),
        .o_pc_plus4 (w_pc_plus4)
    );

    // Word address aliases modulo the memory depth.
    assign ImemAddr = PC[IMEM_AW+1:2];

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_ifid        <= '0;
            r_fetch_count <= '0;
        end else if (w_redirect) begin
            r_ifid <= '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};
        end else if (!Stall) begin
            r_ifid        <= '{instr: ImemData, pc_plus4: w_pc_plus4, valid: 1'b1};
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign Instruction = r_ifid.instr;
    assign PCPlus4     = r_ifid.pc_plus4;
    assign Valid       = r_ifid.valid;
    assign FetchCount  = r_fetch_count;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage and IF/ID pipeline register for the MIPS datapath: the producer end of the 32-bit `Instruction` word that the main controller decodes. It owns the program counter, drives the instruction-memory address, and latches the fetched word plus PC+4 into the IF/ID register. It handles stall (hold), branch/jump redirect and flush (bubble insertion).

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `IMEM_AW`, 7: instruction-memory word-address width (128 words).

Ports:
- `Clk`  in  1  clock; all state updates on rising edge.
- `Rst`  in  1  reset, synchronous, active-low.
- `ImemAddr`  out  IMEM_AW  word address to instruction memory, `PC[IMEM_AW+1:2]`.
- `ImemData`  in  32  instruction word; combinational read of `ImemAddr`.
- `Stall`  in  1  hazard unit: hold PC and IF/ID.
- `BranchTaken`  in  1  branch resolved taken in ID.
- `BranchTarget`  in  32  branch target address.
- `Jump`  in  1  j/jal decoded in ID.
- `JumpTarget`  in  32  jump target address.
- `PC`  out  32  current fetch address.
- `Instruction`  out  32  IF/ID instruction; feeds the controller.
- `PCPlus4`  out  32  IF/ID copy of fetch PC + 4.
- `Valid`  out  1  IF/ID holds a real instruction (0 = bubble).
- `FetchCount`  out  32  number of instructions accepted into IF/ID.

## Operation
- Redirect = `BranchTaken | Jump`. If both are 1, `BranchTarget` wins.
- Next PC priority, highest first:
  - reset → `RESET_PC`
  - redirect → target with bits [1:0] forced to 00
  - `Stall` → hold
  - otherwise `PC + 4`
- IF/ID update priority:
  - reset → `Instruction` = 0, `PCPlus4` = 0, `Valid` = 0
  - redirect → flush: `Instruction` = 32'h0 (NOP, sll $0), `PCPlus4` = 0, `Valid` = 0
  - `Stall` → hold all three
  - otherwise → `Instruction` = `ImemData`, `PCPlus4` = `PC + 4`, `Valid` = 1
- Redirect overrides `Stall`. The wrong-path fetch is discarded even while stalled.
- `FetchCount` increments by 1 exactly on a normal IF/ID load, and wraps at 2^32. It holds on stall, flush and reset-release. It resets to 0.
- PC arithmetic is 32-bit modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- `ImemAddr` truncates the PC: addresses beyond `4*2^IMEM_AW` alias modulo the depth.
- No X may propagate to outputs while `Rst` = 0.

## Timing
- Reset values:
  - `PC` = `RESET_PC`
  - `Instruction` = 0, `PCPlus4` = 0, `Valid` = 0, `FetchCount` = 0
  - `ImemAddr` = `RESET_PC[IMEM_AW+1:2]`
- Reset is sampled only at the clock edge. Asserting it mid-stall or mid-redirect applies the reset values at that edge, and nothing else.
- First instruction appears on `Instruction` one cycle after `Rst` deasserts (edge N+1), with `Valid` = 1.
- Fetch-to-decode latency: 1 cycle. `ImemAddr` is combinational from `PC`.
- Redirect asserted in cycle N:
  - edge N+1: `PC` = target and IF/ID = bubble.
  - edge N+2: target instruction in IF/ID.
  - Penalty: 1 bubble.
- Stall asserted for k cycles: `PC`, `Instruction`, `PCPlus4`, `Valid` and `FetchCount` are all held for k edges, with no lost or duplicated instruction.
- Stall and redirect in the same cycle: the redirect behaviour applies.

## Structure
- Shared package `mips_pkg`:
  - `NOP_INSTR` = 32'h0
  - `DEFAULT_RESET_PC`
  - opcode constants (R-type 000000, j 000010, jal 000011, beq 000100, …), also used by the controller and the branch unit.
- One sub-module, `program_counter`: PC register with reset, load-enable, and redirect mux.
- IF/ID register, flush logic and counter live in `fetch_stage`.

## Test plan
- Reset, then release with imem[0..3] = 0x20080005, 0x20090003, 0x01095020, 0xAC0A0000 and no stall → `Instruction` shows those four words on successive edges. `PCPlus4` = 4, 8, 12, 16; `FetchCount` = 4; `Valid` = 1.
- `Stall` high for 3 cycles while IF/ID holds 0x20090003 → `PC` stays 8, `Instruction` stays 0x20090003, `FetchCount` is unchanged. On release, 0x01095020 arrives next.
- `BranchTaken` = 1 with `BranchTarget` = 0x40 at PC = 0x10 → next edge: `PC` = 0x40, `Instruction` = 0, `Valid` = 0. The following edge delivers imem[16].
- `BranchTaken` and `Jump` both 1 (targets 0x20, 0x60) together with `Stall` = 1 → `PC` = 0x20, IF/ID flushed, `FetchCount` unchanged.
- `Jump` with `JumpTarget` = 0x0000_0023 → `PC` = 0x20 (low bits cleared). Separately, with `RESET_PC` = 0xFFFF_FFFC, the first normal advance gives `PC` = 0 and `PCPlus4` = 0.
- `Rst` driven low for one edge during a stall with `FetchCount` = 7 → all outputs return to their reset values at that edge. Fetch restarts from `RESET_PC` on the next edge.
